// File: rtl/l2_in_sched.sv
// L2 input scheduler: arbitrates rsp/fwd/cpu/flush channels into a
// single-entry issue register and sequences set/way flush walks.
module l2_in_sched #(
    parameter int SETS     = 256,
    parameter int WAYS     = 8,
    parameter int SET_BITS = 8,
    parameter int WAY_BITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rsp_valid,
    output logic                rsp_ready,
    input  logic                fwd_valid,
    output logic                fwd_ready,
    input  logic                cpu_valid,
    output logic                cpu_ready,
    input  logic                flush_valid,
    output logic                flush_ready,
    input  logic                flush_is_all,
    input  logic                fwd_stall,
    input  logic                set_conflict,
    input  logic                evict_stall,
    input  logic                ongoing_atomic,
    input  logic                reqs_empty,
    input  logic                pipe_ready,
    output logic                issue_valid,
    output logic [2:0]          issue_kind,
    output logic [SET_BITS-1:0] flush_set,
    output logic [WAY_BITS-1:0] flush_way,
    output logic                flush_all_q,
    output logic                flush_done,
    output logic                idle
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WALK,
        S_DRAIN
    } state_e;

    localparam logic [2:0] K_NONE = 3'd0;
    localparam logic [2:0] K_RSP  = 3'd1;
    localparam logic [2:0] K_FWD  = 3'd2;
    localparam logic [2:0] K_CPU  = 3'd3;
    localparam logic [2:0] K_STEP = 3'd4;

    localparam logic [SET_BITS-1:0] SET_LAST = SET_BITS'(SETS - 1);
    localparam logic [WAY_BITS-1:0] WAY_LAST = WAY_BITS'(WAYS - 1);

    state_e              state_q, state_d;
    logic                issue_valid_q, issue_valid_d;
    logic [2:0]          issue_kind_q, issue_kind_d;
    logic [SET_BITS-1:0] flush_set_q, flush_set_d;
    logic [WAY_BITS-1:0] flush_way_q, flush_way_d;
    logic [SET_BITS-1:0] cnt_set_q, cnt_set_d;
    logic [WAY_BITS-1:0] cnt_way_q, cnt_way_d;
    logic                flush_all_d;
    logic                flush_done_q, flush_done_d;
    logic                slot_free;
    logic                fwd_ok;
    logic                cpu_ok;

    assign slot_free = !issue_valid_q || pipe_ready;
    assign fwd_ok    = fwd_valid && !fwd_stall;
    assign cpu_ok    = cpu_valid && !set_conflict && !evict_stall
                       && !ongoing_atomic;

    always_comb begin
        state_d       = state_q;
        issue_valid_d = issue_valid_q;
        issue_kind_d  = issue_kind_q;
        flush_set_d   = flush_set_q;
        flush_way_d   = flush_way_q;
        cnt_set_d     = cnt_set_q;
        cnt_way_d     = cnt_way_q;
        flush_all_d   = flush_all_q;
        flush_done_d  = 1'b0;
        rsp_ready     = 1'b0;
        fwd_ready     = 1'b0;
        cpu_ready     = 1'b0;
        flush_ready   = 1'b0;

        if (slot_free) begin
            issue_valid_d = 1'b0;
            issue_kind_d  = K_NONE;
        end

        if (slot_free && !rst) begin
            case (state_q)
                S_IDLE: begin
                    if (rsp_valid) begin
                        rsp_ready     = 1'b1;
                        issue_valid_d = 1'b1;
                        issue_kind_d  = K_RSP;
                    end else if (flush_valid) begin
                        flush_ready = 1'b1;
                        flush_all_d = flush_is_all;
                        cnt_set_d   = '0;
                        cnt_way_d   = '0;
                        state_d     = S_WALK;
                    end else if (fwd_ok) begin
                        fwd_ready     = 1'b1;
                        issue_valid_d = 1'b1;
                        issue_kind_d  = K_FWD;
                    end else if (cpu_ok) begin
                        cpu_ready     = 1'b1;
                        issue_valid_d = 1'b1;
                        issue_kind_d  = K_CPU;
                    end
                end
                S_WALK: begin
                    if (rsp_valid) begin
                        rsp_ready     = 1'b1;
                        issue_valid_d = 1'b1;
                        issue_kind_d  = K_RSP;
                    end else if (fwd_ok) begin
                        fwd_ready     = 1'b1;
                        issue_valid_d = 1'b1;
                        issue_kind_d  = K_FWD;
                    end else begin
                        issue_valid_d = 1'b1;
                        issue_kind_d  = K_STEP;
                        flush_set_d   = cnt_set_q;
                        flush_way_d   = cnt_way_q;
                        // terminal step parks the counters and drains
                        if (cnt_set_q == SET_LAST && cnt_way_q == WAY_LAST) begin
                            state_d = S_DRAIN;
                        end else if (cnt_way_q == WAY_LAST) begin
                            cnt_way_d = '0;
                            cnt_set_d = cnt_set_q + 1'b1;
                        end else begin
                            cnt_way_d = cnt_way_q + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (rsp_valid) begin
                        rsp_ready     = 1'b1;
                        issue_valid_d = 1'b1;
                        issue_kind_d  = K_RSP;
                    end else if (fwd_ok) begin
                        fwd_ready     = 1'b1;
                        issue_valid_d = 1'b1;
                        issue_kind_d  = K_FWD;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (state_q == S_DRAIN && reqs_empty && !issue_valid_q) begin
            flush_done_d = 1'b1;
            flush_all_d  = 1'b0;
            state_d      = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            issue_valid_q <= 1'b0;
            issue_kind_q  <= K_NONE;
            flush_set_q   <= '0;
            flush_way_q   <= '0;
            cnt_set_q     <= '0;
            cnt_way_q     <= '0;
            flush_all_q   <= 1'b0;
            flush_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            issue_valid_q <= issue_valid_d;
            issue_kind_q  <= issue_kind_d;
            flush_set_q   <= flush_set_d;
            flush_way_q   <= flush_way_d;
            cnt_set_q     <= cnt_set_d;
            cnt_way_q     <= cnt_way_d;
            flush_all_q   <= flush_all_d;
            flush_done_q  <= flush_done_d;
        end
    end

    assign issue_valid = issue_valid_q;
    assign issue_kind  = issue_kind_q;
    assign flush_set   = flush_set_q;
    assign flush_way   = flush_way_q;
    assign flush_done  = flush_done_q;
    assign idle        = (state_q == S_IDLE) && !issue_valid_q && reqs_empty;

endmodule

// File: doc/l2_in_sched.md
Name: l2_in_sched

Overview:
Input scheduler for the L2 pipeline. It arbitrates each cycle among the response-in, forward-in, CPU-request and flush channels and issues at most one operation into a single-entry issue register. It sequences flush walks over every set/way and enforces the stall conditions raised by the L2 FSM and request buffers. It sits between the L2 interface queues and the input decoder/lookup stage.

Parameters:
SETS, 256, number of L2 sets
WAYS, 8, number of L2 ways
SET_BITS, 8, log2(SETS)
WAY_BITS, 3, log2(WAYS)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rsp_valid  in  1  response-in pending
rsp_ready  out  1  response accepted this cycle
fwd_valid  in  1  forward-in pending
fwd_ready  out  1  forward accepted this cycle
cpu_valid  in  1  CPU request pending
cpu_ready  out  1  CPU request accepted this cycle
flush_valid  in  1  flush command pending
flush_ready  out  1  flush command accepted this cycle
flush_is_all  in  1  flush includes instruction lines; sampled with flush_ready
fwd_stall  in  1  forwards blocked (MSHR hit pending)
set_conflict  in  1  CPU requests blocked
evict_stall  in  1  CPU requests blocked
ongoing_atomic  in  1  CPU requests blocked
reqs_empty  in  1  request buffer has no live entries
pipe_ready  in  1  downstream consumes the issue register
issue_valid  out  1  issue register holds an operation
issue_kind  out  3  1=rsp 2=fwd 3=cpu 4=flush_step 0=none
flush_set  out  SET_BITS  set of the current flush step
flush_way  out  WAY_BITS  way of the current flush step
flush_all_q  out  1  latched flush_is_all
flush_done  out  1  one-cycle pulse at flush completion
idle  out  1  state IDLE, issue_valid low, reqs_empty high

Behaviour:
- Reset: state IDLE, issue_valid=0, issue_kind=0, flush_set=0, flush_way=0, flush_all_q=0, flush_done=0, all *_ready=0.
- slot_free = !issue_valid | pipe_ready. Selection happens only when slot_free.
- The selected item loads the issue register at the next edge, so issue latency is 1 cycle. issue_valid holds with a stable issue_kind until pipe_ready.
- At most one *_ready is high per cycle, and it is combinational from the current inputs and state.
- Selection in IDLE, highest priority first:
  - rsp_valid
  - flush_valid: accept (flush_ready=1, no issue), latch flush_is_all, clear counters, go to WALK
  - fwd_valid & !fwd_stall
  - cpu_valid & !set_conflict & !evict_stall & !ongoing_atomic
- Selection in WALK, highest priority first:
  - rsp_valid
  - fwd_valid & !fwd_stall
  - flush step: issue_kind=4, flush_set/way hold the step coordinates. The step does not depend on the cpu stall inputs.
  - CPU requests and new flushes are never accepted.
- Walk order: way is the inner loop, set the outer. The step counter advances only when a step is loaded. Way wraps WAYS-1→0 and set increments at the wrap.
- When step (SETS-1, WAYS-1) is loaded, go to DRAIN. Counters are not advanced past it.
- DRAIN:
  - rsp and fwd accepted as in WALK, with no steps.
  - When reqs_empty & !issue_valid: pulse flush_done for 1 cycle, clear flush_all_q, return to IDLE.
- A flush_valid arriving while an issued op is stalled waits; flush_ready is low until slot_free.
- rst asserted mid-walk or mid-drain: next cycle all state is at reset values, and no flush_done is emitted.
- Counters have width SET_BITS/WAY_BITS with no overflow past terminal values.
- idle is combinational.

Test Plan:
- Reset, then rsp/fwd/cpu valid together with pipe_ready=1 → rsp_ready cycle 0, fwd_ready cycle 1, cpu_ready cycle 2; issue_kind 1,2,3 appear one cycle after each ready.
- cpu_valid=1, set_conflict=1 for 5 cycles then 0 → cpu_ready stays low for 5 cycles, then rises in the cycle set_conflict=0.
- Backpressure: issue rsp, pipe_ready=0 for 3 cycles → issue_valid=1 with issue_kind=1 held for 3 cycles; no other *_ready asserts.
- Flush with SETS=4, WAYS=2, pipe_ready=1, reqs_empty=1:
  - flush_ready, then 8 steps (0,0),(0,1),(1,0)…(3,1).
  - flush_done pulses exactly once after the last step drains.
  - cpu_ready stays 0 throughout.
- Mid-walk interleave: rsp_valid at step (1,0) → rsp issued before (1,0); fwd_stall=1 blocks the fwd while steps continue.
- DRAIN hold: reqs_empty=0 for 4 cycles after the last step → no flush_done until 1 cycle after reqs_empty=1.
- Reset mid-walk at step (2,1) → counters return to 0, state IDLE, flush_done never pulses.
